// File: rtl/osecpu_pkg.sv
// Shared constants and state encoding for the program loader that feeds
// instruction memory before the CPU core is released from reset.
package osecpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHK    = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Collects payload bytes into big-endian instruction words and keeps the
// running XOR checksum over length and payload bytes.
module loader_word_assembler
  import osecpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              xor_en,
  input  logic              shift_en,
  input  logic [7:0]        data_byte,
  output logic [DATA_W-1:0] word_next,
  output logic              word_ready,
  output logic [7:0]        checksum
);

  // Only the first three bytes are buffered; the fourth completes word_next.
  logic [DATA_W-9:0] word_r;
  logic [1:0]        byte_idx_r;
  logic [7:0]        checksum_r;

  // Byte shift register, byte index and checksum accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_r     <= '0;
      byte_idx_r <= 2'd0;
      checksum_r <= 8'h00;
    end else if (clear) begin
      word_r     <= '0;
      byte_idx_r <= 2'd0;
      checksum_r <= 8'h00;
    end else begin
      if (xor_en) begin
        checksum_r <= checksum_r ^ data_byte;
      end
      if (shift_en) begin
        word_r     <= {word_r[DATA_W-17:0], data_byte};
        byte_idx_r <= byte_idx_r + 2'd1;
      end
    end
  end

  assign word_next  = {word_r, data_byte};
  assign word_ready = (byte_idx_r == 2'd3);
  assign checksum   = checksum_r;

endmodule

// File: rtl/program_loader.sv
// Frame-driven image loader: writes checksum-protected words into instruction
// memory and holds the CPU in reset until a verified image is present.
module program_loader #(
  parameter int         ADDR_W    = osecpu_pkg::ADDR_W,
  parameter int         DATA_W    = osecpu_pkg::DATA_W,
  parameter logic [7:0] SYNC_BYTE = osecpu_pkg::SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import osecpu_pkg::*;

  localparam int IDX_W = ADDR_W + 1;

  loader_state_t     state_r;
  loader_state_t     state_next;
  logic [15:0]       len_r;
  logic [IDX_W-1:0]  word_idx_r;
  logic [IDX_W-1:0]  word_idx_inc_s;
  logic [IDX_W-1:0]  len_ext_s;
  logic              accept_s;
  logic              clear_s;
  logic              xor_en_s;
  logic              shift_en_s;
  logic              word_ready_s;
  logic [DATA_W-1:0] word_next_s;
  logic [7:0]        checksum_s;

  logic              rx_ready_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_we_r;
  logic              cpu_hold_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  assign accept_s       = rx_valid && rx_ready_r;
  assign word_idx_inc_s = word_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
  assign len_ext_s      = IDX_W'(len_r);

  loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_s),
    .xor_en     (xor_en_s),
    .shift_en   (shift_en_s),
    .data_byte  (rx_data),
    .word_next  (word_next_s),
    .word_ready (word_ready_s),
    .checksum   (checksum_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state decode and per-byte assembler controls.
  always_comb begin
    state_next = state_r;
    clear_s    = 1'b0;
    xor_en_s   = 1'b0;
    shift_en_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (accept_s && (rx_data == SYNC_BYTE)) begin
          state_next = ST_LEN_HI;
          clear_s    = 1'b1;
        end else begin
          state_next = state_r;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          xor_en_s   = 1'b1;
          state_next = ST_LEN_LO;
        end else begin
          state_next = ST_LEN_HI;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          xor_en_s = 1'b1;
          if ({len_r[15:8], rx_data} == 16'd0) begin
            state_next = ST_CHK;
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_LEN_LO;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          xor_en_s   = 1'b1;
          shift_en_s = 1'b1;
          if (word_ready_s) begin
            state_next = ST_WRITE;
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (word_idx_inc_s == len_ext_s) begin
          state_next = ST_CHK;
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_CHK: begin
        if (accept_s) begin
          if (rx_data == checksum_s) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ERR;
          end
        end else begin
          state_next = ST_CHK;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so each flop lines up with its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready_r  <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_we_r    <= 1'b0;
      cpu_hold_r  <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      len_r       <= 16'd0;
      word_idx_r  <= '0;
    end else begin
      rx_ready_r <= (state_next != ST_WRITE);
      mem_we_r   <= (state_next == ST_WRITE);
      cpu_hold_r <= (state_next != ST_DONE);
      busy_r     <= (state_next != ST_IDLE) && (state_next != ST_DONE) &&
                    (state_next != ST_ERR);
      done_r     <= (state_next == ST_DONE);
      err_r      <= (state_next == ST_ERR);
      if (clear_s) begin
        len_r      <= 16'd0;
        word_idx_r <= '0;
      end else if (state_r == ST_WRITE) begin
        word_idx_r <= word_idx_inc_s;
      end
      if ((state_r == ST_LEN_HI) && accept_s) begin
        len_r[15:8] <= rx_data;
      end
      if ((state_r == ST_LEN_LO) && accept_s) begin
        len_r[7:0] <= rx_data;
      end
      if ((state_r == ST_DATA) && (state_next == ST_WRITE)) begin
        mem_addr_r  <= word_idx_r[ADDR_W-1:0];
        mem_wdata_r <= word_next_s;
      end
    end
  end

  assign rx_ready  = rx_ready_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign cpu_hold  = cpu_hold_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Streams a program image from a byte source (UART receiver or host bridge) into instruction Memory through its write port (addr / wdata / we).
- Is the writer that the CPU's fetch path reads from.
- Holds the CPU core in reset while loading and releases it only after a checksum-verified image has been written from address 0.
- Sits beside top's Memory instance and muxes onto the Memory address lines while loading.

Parameters:
- ADDR_W, 16, Memory word-address width (matches pc width).
- DATA_W, 32, instruction word width; fixed at 4 bytes per word.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts the byte this cycle; a transfer occurs when rx_valid && rx_ready.
- mem_addr  out  ADDR_W  Memory write address.
- mem_wdata  out  DATA_W  Memory write data.
- mem_we  out  1  one-cycle Memory write strobe.
- cpu_hold  out  1  drives the CPU core's reset; high while no valid image is loaded.
- busy  out  1  a frame is in progress.
- done  out  1  last frame loaded OK; sticky until the next SYNC_BYTE.
- err  out  1  last frame failed its checksum; sticky until the next SYNC_BYTE.

Behaviour:
- Frame format:
  - SYNC_BYTE.
  - LEN_HI, LEN_LO: N, the word count, 16-bit big-endian.
  - N×4 payload bytes, each word big-endian (first byte goes to bits [31:24]).
  - CHK: XOR of all LEN and payload bytes.
- Reset (reset=0, async) values:
  - state=IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, busy=0, done=0, err=0.
  - Internal counters and checksum cleared.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR.
- IDLE / DONE / ERR:
  - rx_ready=1.
  - A byte equal to SYNC_BYTE goes to LEN_HI; clears done, err, checksum, word index and byte index; sets cpu_hold=1 and busy=1.
  - Any other byte is consumed and dropped; state unchanged.
- LEN_HI, LEN_LO:
  - Each accepted byte is XORed into the checksum and stored into the length register.
  - After LEN_LO: N==0 goes to CHK, else goes to DATA.
- DATA:
  - rx_ready=1. Each accepted byte shifts into the word register; byte index increments 0..3.
  - On byte index 3 go to WRITE.
- WRITE (exactly one cycle):
  - rx_ready=0, mem_we=1, mem_addr=word index, mem_wdata=assembled word.
  - Latency: 4th byte accepted at cycle t gives mem_we high at t+1 only.
  - Word index increments. If the index now equals N go to CHK, else go to DATA.
- CHK:
  - rx_ready=1. On an accepted byte, compare it with the running checksum.
  - Match: go to DONE, done=1, cpu_hold=0 at t+1.
  - Mismatch: go to ERR, err=1, cpu_hold stays 1.
- busy=1 in LEN_HI through CHK.
- mem_addr and mem_wdata hold their last values outside WRITE; mem_we=0 everywhere except WRITE.
- N=65535 writes addresses 0..65534; the word index is ADDR_W+1 bits wide so the compare never wraps.
- A SYNC_BYTE value inside LEN, payload or CHK is data, not a restart.
- rx_valid low stalls any state indefinitely; there is no timeout.
- Reset mid-frame aborts immediately.
  - Memory contents already written are not cleared.
  - cpu_hold returns to 1 and done returns to 0.
- A reload from DONE re-asserts cpu_hold in the cycle after the SYNC byte is accepted.

Decomposition:
- Shared package (osecpu_pkg) holds:
  - Constants: SYNC_BYTE, ADDR_W, DATA_W.
  - The state enum for program_loader.
- One natural sub-module: loader_word_assembler.
  - Holds the byte shift register, byte index and running XOR checksum.
  - Exposes word_ready and checksum outputs.
- FSM and address counter stay in program_loader.

Test Plan:
- Frame A5 00 02 | 02 04 00 07 | 14 00 01 00 | chk=0x02^0x02^0x04^0x07^0x14^0x01 -> two mem_we pulses at addr 0 with 0x02040007 and addr 1 with 0x14000100, each 1 cycle after its 4th byte; done=1, cpu_hold=0.
- Same frame with wrong chk (0xFF) -> both writes still occur; err=1, done=0, cpu_hold=1; a following correct frame clears err and sets done.
- Leading garbage 00 FF 12, then frame A5 00 00 00 -> garbage dropped, no mem_we; done=1 after CHK=0x00.
- rx_valid toggled randomly during payload, including a stall across the WRITE cycle -> rx_ready=0 exactly in WRITE; no bytes lost or duplicated; data identical to the unstalled case.
- reset driven low after 2 payload bytes -> outputs return to reset values asynchronously; cpu_hold=1; no further mem_we; a new frame loads correctly.
- Payload word containing 0xA5 bytes (0xA5A5A5A5) -> written verbatim, no resync.
